// File: rtl/fabric_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_cfg_pkg
//  Description : Shared types and constants for the fabric frame configuration
//                loader: FSM state encoding, bitstream marker words and
//                header field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package fabric_cfg_pkg;

    // Loader FSM states. ST_CRC is only reachable when CONFIG_CRC_EN is set.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CRC    = 3'd3,
        ST_STROBE = 3'd4
    } cfg_state_t;

    // Bitstream markers
    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_DE5C;

    // Frame header layout
    localparam int COL_MSB = 31;
    localparam int COL_LSB = 24;
    localparam int FRM_MSB = 23;
    localparam int FRM_LSB = 16;
    localparam int COL_W   = COL_MSB - COL_LSB + 1;
    localparam int FRM_W   = FRM_MSB - FRM_LSB + 1;

    function automatic logic [COL_W-1:0] hdr_col(input logic [31:0] word);
        return word[COL_MSB:COL_LSB];
    endfunction

    function automatic logic [FRM_W-1:0] hdr_frame(input logic [31:0] word);
        return word[FRM_MSB:FRM_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : frame_strobe_decoder
//  Description : Combinational column/frame decoder. Drives exactly one
//                FrameStrobe bit (col*MAX_FRAMES_PER_COL + frame) while i_fire
//                is high and the address is in range; flags out-of-range
//                addresses independently of i_fire.
//  Ports       : i_col, i_frame    - latched header address fields
//                i_fire            - strobe enable (FSM in STROBE)
//                o_strobe          - one-hot strobe vector, all 0 when idle
//                o_out_of_range    - col >= NUM_COLS or frame >= MAX_FRAMES_PER_COL
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_strobe_decoder
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_COLS           = 8,
    parameter int MAX_FRAMES_PER_COL = 20
) (
    input  logic [COL_W-1:0]                        i_col,
    input  logic [FRM_W-1:0]                        i_frame,
    input  logic                                    i_fire,
    output logic [NUM_COLS*MAX_FRAMES_PER_COL-1:0]  o_strobe,
    output logic                                    o_out_of_range
);

    localparam logic [31:0] c_num_cols   = 32'(NUM_COLS);
    localparam logic [31:0] c_num_frames = 32'(MAX_FRAMES_PER_COL);

    assign o_out_of_range = (32'(i_col) >= c_num_cols) || (32'(i_frame) >= c_num_frames);

    // Each bit matches only its own in-range address, so an out-of-range
    // header can never light any strobe bit.
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
        for (genvar gf = 0; gf < MAX_FRAMES_PER_COL; gf++) begin : g_frame
            assign o_strobe[gc*MAX_FRAMES_PER_COL + gf] =
                i_fire && (i_col == COL_W'(gc)) && (i_frame == FRM_W'(gf));
        end
    end

endmodule
`default_nettype wire

// File: rtl/fabric_frame_config_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_frame_config_ctrl
//  Description : Frame-based configuration loader. Consumes a 32-bit
//                valid/ready word stream, waits for SYNC_WORD, decodes a frame
//                header (column/frame address), assembles NUM_ROWS data words
//                into FrameData (word 0 = top row) and pulses the addressed
//                FrameStrobe bit for one cycle. DESYNC_WORD in place of a
//                header ends the bitstream.
//  Build macro : CONFIG_CRC_EN - when defined, each frame carries a trailing
//                CRC word (XOR of header and data words); a mismatch
//                suppresses the strobe and sets cfg_err.
//  Ports       : CLK, RESET        - clock, synchronous active-high reset
//                cfg_word/valid/ready - config stream handshake
//                FrameData         - assembled frame, 32*NUM_ROWS bits
//                FrameStrobe       - one-hot frame strobe, 1-cycle pulse
//                cfg_busy          - FSM not in IDLE
//                cfg_done          - 1-cycle pulse after DESYNC_WORD accepted
//                cfg_err           - sticky address/CRC error
//  Revision    : 1.0 - initial release
// ============================================================================
module fabric_frame_config_ctrl
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_ROWS           = 16,
    parameter int NUM_COLS           = 8,
    parameter int MAX_FRAMES_PER_COL = 20
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic [31:0]                             cfg_word,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    output logic [32*NUM_ROWS-1:0]                  FrameData,
    output logic [NUM_COLS*MAX_FRAMES_PER_COL-1:0]  FrameStrobe,
    output logic                                    cfg_busy,
    output logic                                    cfg_done,
    output logic                                    cfg_err
);

    localparam int                 c_cnt_w    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_row = c_cnt_w'(NUM_ROWS - 1);

    cfg_state_t          r_state;
    cfg_state_t          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [COL_W-1:0]    r_col;
    logic [FRM_W-1:0]    r_frame;
    logic [31:0]         r_rows [NUM_ROWS];
    logic                r_done;
    logic                r_err;
    logic                w_accept;
    logic                w_fire;
    logic                w_oor;
`ifdef CONFIG_CRC_EN
    logic [31:0]         r_crc;
`endif

    // Ready depends on registered state only: no cfg_valid -> cfg_ready path.
    assign cfg_ready = (r_state != ST_STROBE);
    assign cfg_busy  = (r_state != ST_IDLE);
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign w_accept  = cfg_valid & cfg_ready;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / strobe enable
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (cfg_word == SYNC_WORD)) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (w_accept) begin
                    if (cfg_word == DESYNC_WORD) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept && (r_cnt == c_last_row)) begin
`ifdef CONFIG_CRC_EN
                    w_state_nxt = ST_CRC;
`else
                    w_state_nxt = ST_STROBE;
`endif
                end
            end
`ifdef CONFIG_CRC_EN
            ST_CRC: begin
                if (w_accept) begin
                    if (cfg_word == r_crc) begin
                        w_state_nxt = ST_STROBE;
                    end else begin
                        w_state_nxt = ST_HEADER;
                    end
                end
            end
`endif
            ST_STROBE: begin
                w_fire      = 1'b1;
                w_state_nxt = ST_HEADER;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: header latch, row capture, status flags
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_col   <= '0;
            r_frame <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_rows[i] <= '0;
            end
`ifdef CONFIG_CRC_EN
            r_crc   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (cfg_word == SYNC_WORD)) begin
                        r_err <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    if (w_accept) begin
                        if (cfg_word == DESYNC_WORD) begin
                            r_done <= 1'b1;
                        end else begin
                            r_col   <= hdr_col(cfg_word);
                            r_frame <= hdr_frame(cfg_word);
                            r_cnt   <= '0;
`ifdef CONFIG_CRC_EN
                            r_crc   <= cfg_word;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_rows[r_cnt] <= cfg_word;
                        r_cnt         <= r_cnt + c_cnt_w'(1);
`ifdef CONFIG_CRC_EN
                        r_crc         <= r_crc ^ cfg_word;
`endif
                    end
                end
`ifdef CONFIG_CRC_EN
                ST_CRC: begin
                    if (w_accept && (cfg_word != r_crc)) begin
                        r_err <= 1'b1;
                    end
                end
`endif
                ST_STROBE: begin
                    // Frame was consumed but had nowhere to go.
                    if (w_oor) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Row 0 occupies the most significant 32 bits of FrameData.
    for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_row
        assign FrameData[32*(NUM_ROWS-gr)-1 -: 32] = r_rows[gr];
    end

    frame_strobe_decoder #(
        .NUM_COLS           (NUM_COLS),
        .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL)
    ) u_strobe_dec (
        .i_col          (r_col),
        .i_frame        (r_frame),
        .i_fire         (w_fire),
        .o_strobe       (FrameStrobe),
        .o_out_of_range (w_oor)
    );

endmodule
`default_nettype wire

// File: tb/tb_fabric_frame_config_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fabric_frame_config_ctrl
//  Description : Self-checking bench for fabric_frame_config_ctrl. Random
//                frames are checked against a frame-level reference model
//                (expected strobe list, expected frame image, sticky error).
//                Honours CONFIG_CRC_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_frame_config_ctrl;

    localparam int NR = 16;
    localparam int NC = 8;
    localparam int NF = 20;
    localparam int SW = NC * NF;
    localparam int DW = 32 * NR;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_DE5C;
`ifdef CONFIG_CRC_EN
    localparam int WORDS_PER_FRAME = NR + 2;
`else
    localparam int WORDS_PER_FRAME = NR + 1;
`endif
    localparam int FRAME_CYC = WORDS_PER_FRAME + 1;

    typedef struct {
        int              idx;
        int              nbits;
        logic [DW-1:0]   data;
        int              acc;
        int              cyc;
    } sev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    cfg_word;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [DW-1:0]  frame_data;
    logic [SW-1:0]  frame_strobe;
    logic           cfg_busy;
    logic           cfg_done;
    logic           cfg_err;

    int   checks = 0;
    int   errors = 0;
    bit   model_err;
    sev_t exp_q[$];

    // monitor state
    sev_t mon_q[$];
    int   cyc          = 0;
    int   acc_cnt      = 0;
    int   last_acc_cyc = -1;
    int   nr_cnt       = 0;
    int   last_nr_cyc  = -1;

    always #5 clk = ~clk;

    fabric_frame_config_ctrl #(
        .NUM_ROWS           (NR),
        .NUM_COLS           (NC),
        .MAX_FRAMES_PER_COL (NF)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .cfg_word    (cfg_word),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .FrameData   (frame_data),
        .FrameStrobe (frame_strobe),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err)
    );

    function automatic int first_one(input logic [SW-1:0] v);
        int r;
        r = -1;
        for (int i = SW - 1; i >= 0; i--) begin
            if (v[i] === 1'b1) r = i;
        end
        return r;
    endfunction

    // Expected frame image: word 0 shifts all the way to the top.
    function automatic logic [DW-1:0] model_data(input logic [31:0] w [NR]);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NR; k++) d = (d << 32) | DW'(w[k]);
        return d;
    endfunction

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
        if (cfg_ready === 1'b0) begin
            nr_cnt      <= nr_cnt + 1;
            last_nr_cyc <= cyc;
        end
        if (|frame_strobe) begin
            mon_q.push_back('{first_one(frame_strobe), $countones(frame_strobe), frame_data, acc_cnt, cyc});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Drive one word and hold it until accepted; optional random idle gaps first.
    task automatic push(input logic [31:0] w, input int gap);
        int guard;
        bit acc;
        guard = 0;
        acc   = 1'b0;
        while (gap > 0 && $urandom_range(99, 0) < gap) begin
            cfg_valid = 1'b0;
            cfg_word  = $urandom;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b1;
        cfg_word  = w;
        while (!acc && guard < 20) begin
            @(negedge clk);
            acc = (cfg_ready === 1'b1);
            @(posedge clk); #1;
            guard++;
        end
        cfg_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_timeout: word %08h not accepted within %0d cycles", w, guard);
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] col, input logic [7:0] frm,
                             input logic [31:0] w [NR], input int gap, input bit bad_crc);
        logic [31:0] hdr;
        logic [31:0] crc;
        bit          in_range;
        bit          crc_fail;
        hdr = {col, frm, 16'($urandom)};
        crc = hdr;
        push(hdr, gap);
        for (int k = 0; k < NR; k++) begin
            push(w[k], gap);
            crc = crc ^ w[k];
        end
`ifdef CONFIG_CRC_EN
        push(bad_crc ? (crc ^ 32'd1) : crc, gap);
        crc_fail = bad_crc;
`else
        crc_fail = 1'b0;
`endif
        in_range = (int'(col) < NC) && (int'(frm) < NF);
        if (in_range && !crc_fail)
            exp_q.push_back('{int'(col) * NF + int'(frm), 1, model_data(w), 0, 0});
        else
            model_err = 1'b1;
    endtask

    // From IDLE or HEADER, land in HEADER with the error flag cleared.
    task automatic enter_header();
        push(DESYNC, 0);
        push(SYNC, 0);
        model_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        checks++; if (frame_data !== '0)   begin errors++; $display("FAIL reset_framedata got=%0h exp=0", frame_data); end
        checks++; if (frame_strobe !== '0) begin errors++; $display("FAIL reset_strobe got=%0h exp=0", frame_strobe); end
        checks++; if (cfg_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", cfg_busy); end
        checks++; if (cfg_done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", cfg_done); end
        checks++; if (cfg_err !== 1'b0)    begin errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_err = 1'b0;
    endtask

    task automatic test_basic_frame();
        logic [31:0] w [NR];
        int   q0;
        sev_t ev;
        for (int k = 0; k < NR; k++) w[k] = 32'(k);
        q0 = mon_q.size();
        push(SYNC, 0);
        @(negedge clk);
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_sync got=%b exp=1", cfg_busy); end
        @(posedge clk); #1;
        run_frame(8'd0, 8'd0, w, 0, 1'b0);
        settle();
        checks++; if (mon_q.size() !== q0 + 1) begin errors++; $display("FAIL basic_strobe_count got=%0d exp=%0d", mon_q.size() - q0, 1); end
        if (mon_q.size() > q0) begin
            ev = mon_q[q0];
            checks++; if (ev.idx !== 0)   begin errors++; $display("FAIL basic_strobe_idx got=%0d exp=0", ev.idx); end
            checks++; if (ev.nbits !== 1) begin errors++; $display("FAIL basic_strobe_onehot got=%0d exp=1", ev.nbits); end
            checks++; if (ev.data !== model_data(w)) begin errors++; $display("FAIL basic_strobe_data got=%0h exp=%0h", ev.data, model_data(w)); end
            checks++; if (ev.cyc !== last_acc_cyc + 1) begin errors++; $display("FAIL basic_strobe_latency got=%0d exp=%0d", ev.cyc, last_acc_cyc + 1); end
        end
        checks++; if (frame_data[511:480] !== 32'd0) begin errors++; $display("FAIL basic_top_row got=%0h exp=0", frame_data[511:480]); end
        checks++; if (frame_data[31:0] !== 32'd15)   begin errors++; $display("FAIL basic_bottom_row got=%0h exp=f", frame_data[31:0]); end
        push(DESYNC, 0);
        @(negedge clk);
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got=%b exp=1", cfg_done); end
        @(negedge clk);
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", cfg_done); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", cfg_busy); end
        checks++; if (cfg_err !== model_err) begin errors++; $display("FAIL basic_err got=%b exp=%b", cfg_err, model_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_corner_addr();
        logic [31:0] w [NR];
        int   q0, nr0;
        sev_t ev;
        for (int k = 0; k < NR; k++) w[k] = $urandom;
        enter_header();
        q0 = mon_q.size(); nr0 = nr_cnt;
        run_frame(8'd7, 8'd19, w, 0, 1'b0);
        settle();
        checks++; if (mon_q.size() !== q0 + 1) begin errors++; $display("FAIL corner_strobe_count got=%0d exp=1", mon_q.size() - q0); end
        checks++; if (nr_cnt - nr0 !== 1) begin errors++; $display("FAIL corner_notready_cycles got=%0d exp=1", nr_cnt - nr0); end
        if (mon_q.size() > q0) begin
            ev = mon_q[q0];
            checks++; if (ev.idx !== 159)  begin errors++; $display("FAIL corner_strobe_idx got=%0d exp=159", ev.idx); end
            checks++; if (ev.nbits !== 1)  begin errors++; $display("FAIL corner_strobe_onehot got=%0d exp=1", ev.nbits); end
            checks++; if (ev.cyc !== last_nr_cyc) begin errors++; $display("FAIL corner_ready_low_cycle got=%0d exp=%0d", last_nr_cyc, ev.cyc); end
            checks++; if (ev.data !== model_data(w)) begin errors++; $display("FAIL corner_strobe_data got=%0h exp=%0h", ev.data, model_data(w)); end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] w [NR];
        int q0, nr0;
        for (int k = 0; k < NR; k++) w[k] = $urandom;
        enter_header();
        q0 = mon_q.size(); nr0 = nr_cnt;
        run_frame(8'd8, 8'd0, w, 0, 1'b0);
        settle();
        checks++; if (mon_q.size() !== q0) begin errors++; $display("FAIL oor_col_strobe got=%0d exp=0", mon_q.size() - q0); end
        checks++; if (nr_cnt - nr0 !== 1)  begin errors++; $display("FAIL oor_col_notready got=%0d exp=1", nr_cnt - nr0); end
        checks++; if (cfg_err !== model_err) begin errors++; $display("FAIL oor_col_err got=%b exp=%b", cfg_err, model_err); end
        checks++; if (frame_data !== model_data(w)) begin errors++; $display("FAIL oor_col_data got=%0h exp=%0h", frame_data, model_data(w)); end
        for (int k = 0; k < NR; k++) w[k] = $urandom;
        run_frame(8'd2, 8'd5, w, 0, 1'b0);
        settle();
        checks++; if (mon_q.size() !== q0 + 1) begin errors++; $display("FAIL oor_good_strobe got=%0d exp=1", mon_q.size() - q0); end
        checks++; if (cfg_err !== model_err) begin errors++; $display("FAIL oor_sticky_err got=%b exp=%b", cfg_err, model_err); end
        run_frame(8'd0, 8'd20, w, 0, 1'b0);
        settle();
        checks++; if (mon_q.size() !== q0 + 1) begin errors++; $display("FAIL oor_frame_strobe got=%0d exp=0", mon_q.size() - q0 - 1); end
        push(DESYNC, 0);
        push(32'h1234_5678, 0);
        settle();
        checks++; if (cfg_err !== model_err) begin errors++; $display("FAIL oor_err_in_idle got=%b exp=%b", cfg_err, model_err); end
        push(SYNC, 0);
        model_err = 1'b0;
        @(negedge clk);
        checks++; if (cfg_err !== model_err) begin errors++; $display("FAIL oor_err_clear got=%b exp=%b", cfg_err, model_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_valid_gaps();
        logic [31:0] w [NR];
        logic [7:0]  col, frm;
        int   q0, acc0;
        sev_t ev_a, ev_b;
        for (int k = 0; k < NR; k++) w[k] = $urandom;
        col = 8'($urandom_range(NC - 1, 0));
        frm = 8'($urandom_range(NF - 1, 0));
        enter_header();
        q0 = mon_q.size();
        run_frame(col, frm, w, 0, 1'b0);
        settle();
        acc0 = acc_cnt;
        run_frame(col, frm, w, 50, 1'b0);
        settle();
        checks++; if (mon_q.size() !== q0 + 2) begin errors++; $display("FAIL gaps_strobe_count got=%0d exp=2", mon_q.size() - q0); end
        if (mon_q.size() >= q0 + 2) begin
            ev_a = mon_q[q0];
            ev_b = mon_q[q0 + 1];
            checks++; if (ev_b.data !== ev_a.data) begin errors++; $display("FAIL gaps_vs_nogap got=%0h exp=%0h", ev_b.data, ev_a.data); end
            checks++; if (ev_b.data !== model_data(w)) begin errors++; $display("FAIL gaps_data got=%0h exp=%0h", ev_b.data, model_data(w)); end
            checks++; if (ev_b.idx !== int'(col) * NF + int'(frm)) begin errors++; $display("FAIL gaps_idx got=%0d exp=%0d", ev_b.idx, int'(col) * NF + int'(frm)); end
            checks++; if (ev_b.acc - acc0 !== WORDS_PER_FRAME) begin errors++; $display("FAIL gaps_accept_count got=%0d exp=%0d", ev_b.acc - acc0, WORDS_PER_FRAME); end
            checks++; if (ev_b.cyc !== last_acc_cyc + 1) begin errors++; $display("FAIL gaps_latency got=%0d exp=%0d", ev_b.cyc, last_acc_cyc + 1); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w;
        int q0;
        enter_header();
        q0 = mon_q.size();
        push({8'd1, 8'd1, 16'h0}, 0);
        for (int k = 0; k < 5; k++) push(32'hA5A5_0000 | 32'(k), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (cfg_busy !== 1'b0)   begin errors++; $display("FAIL midreset_busy got=%b exp=0", cfg_busy); end
        checks++; if (frame_data !== '0)   begin errors++; $display("FAIL midreset_data got=%0h exp=0", frame_data); end
        checks++; if (cfg_ready !== 1'b1)  begin errors++; $display("FAIL midreset_ready got=%b exp=1", cfg_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_err = 1'b0;
        for (int k = 0; k < 12; k++) begin
            w = $urandom;
            if (w == SYNC) w = w ^ 32'd1;
            push(w, 0);
        end
        settle();
        checks++; if (mon_q.size() !== q0) begin errors++; $display("FAIL midreset_no_strobe got=%0d exp=0", mon_q.size() - q0); end
        checks++; if (cfg_busy !== 1'b0)   begin errors++; $display("FAIL midreset_ignored got=%b exp=0", cfg_busy); end
        checks++; if (frame_data !== '0)   begin errors++; $display("FAIL midreset_data_held got=%0h exp=0", frame_data); end
        push(SYNC, 0);
        @(negedge clk);
        checks++; if (cfg_busy !== 1'b1)   begin errors++; $display("FAIL midreset_resync got=%b exp=1", cfg_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [NR];
        logic [7:0]  col, frm;
        int q0, r, n;
        enter_header();
        q0 = mon_q.size();
        exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            if (f == 2) begin
                col = 8'(NC); frm = 8'($urandom_range(NF - 1, 0));
            end else if (f == 0 || f == 5) begin
                col = 8'($urandom_range(NC - 1, 0)); frm = 8'($urandom_range(NF - 1, 0));
            end else begin
                col = 8'($urandom_range(NC + 1, 0)); frm = 8'($urandom_range(NF + 1, 0));
            end
            for (int k = 0; k < NR; k++) begin
                r = $urandom_range(9, 0);
                w[k] = (r == 0) ? SYNC : (r == 1) ? DESYNC : 32'($urandom);
            end
            run_frame(col, frm, w, 0, 1'b0);
        end
        settle();
        n = mon_q.size() - q0;
        checks++; if (n !== exp_q.size()) begin errors++; $display("FAIL b2b_strobe_count got=%0d exp=%0d", n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            checks++; if (mon_q[q0 + i].idx !== exp_q[i].idx) begin errors++; $display("FAIL b2b_idx[%0d] got=%0d exp=%0d", i, mon_q[q0 + i].idx, exp_q[i].idx); end
            checks++; if (mon_q[q0 + i].data !== exp_q[i].data) begin errors++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, mon_q[q0 + i].data, exp_q[i].data); end
        end
        if (n >= 2) begin
            checks++; if (mon_q[q0 + n - 1].cyc - mon_q[q0].cyc !== FRAME_CYC * 5) begin errors++; $display("FAIL b2b_throughput got=%0d exp=%0d", mon_q[q0 + n - 1].cyc - mon_q[q0].cyc, FRAME_CYC * 5); end
        end
        checks++; if (cfg_err !== model_err) begin errors++; $display("FAIL b2b_err got=%b exp=%b", cfg_err, model_err); end
    endtask

`ifdef CONFIG_CRC_EN
    task automatic test_crc();
        logic [31:0] w [NR];
        int q0, nr0;
        for (int k = 0; k < NR; k++) w[k] = $urandom;
        enter_header();
        q0 = mon_q.size(); nr0 = nr_cnt;
        run_frame(8'd3, 8'd4, w, 0, 1'b0);
        run_frame(8'd5, 8'd6, w, 0, 1'b1);
        settle();
        checks++; if (mon_q.size() !== q0 + 1) begin errors++; $display("FAIL crc_strobe_count got=%0d exp=1", mon_q.size() - q0); end
        if (mon_q.size() > q0) begin
            checks++; if (mon_q[q0].idx !== 3 * NF + 4) begin errors++; $display("FAIL crc_good_idx got=%0d exp=%0d", mon_q[q0].idx, 3 * NF + 4); end
        end
        checks++; if (nr_cnt - nr0 !== 1) begin errors++; $display("FAIL crc_notready got=%0d exp=1", nr_cnt - nr0); end
        checks++; if (cfg_err !== model_err) begin errors++; $display("FAIL crc_err got=%b exp=%b", cfg_err, model_err); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_word  = '0;
        model_err = 1'b0;
        test_reset();
        test_basic_frame();
        test_corner_addr();
        test_out_of_range();
        test_valid_gaps();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef CONFIG_CRC_EN
        test_crc();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
